// File: rtl/seq_detect_counter_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_detect_counter_if
//
// Purpose: groups the user-facing signals of seq_detect_counter so the
// detector and whatever drives it can be connected with a single port.
// Clock and reset are not part of this interface.
//
// Signals:
//   data_in        serial data bit (switch level), asynchronous to clk
//   step_in        step strobe (debounced button level), asynchronous to clk
//   clear_in       synchronous active-high clear, already in the clk domain
//   detect_counter 8-bit saturating count of pattern matches
//   detect_pulse   one-cycle pulse per match
//   saturated      high while detect_counter equals its saturation value
//   history        last PAT_LEN sampled bits, newest in bit 0
//
// Modports:
//   master  the stimulus side (drives the inputs, observes the results)
//   slave   the detector side
// -----------------------------------------------------------------------------
interface seq_detect_counter_if #(
  parameter int PAT_LEN = 4
);

  logic               data_in;
  logic               step_in;
  logic               clear_in;
  logic [7:0]         detect_counter;
  logic               detect_pulse;
  logic               saturated;
  logic [PAT_LEN-1:0] history;

  modport master (
    output data_in,
    output step_in,
    output clear_in,
    input  detect_counter,
    input  detect_pulse,
    input  saturated,
    input  history
  );

  modport slave (
    input  data_in,
    input  step_in,
    input  clear_in,
    output detect_counter,
    output detect_pulse,
    output saturated,
    output history
  );

endinterface

// File: rtl/seq_detect_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_detect_counter
//
// Purpose: samples a serial data bit on every rising edge of a user step
// strobe, looks for a fixed bit pattern in the received stream and keeps an
// 8-bit saturating count of matches. The count feeds the seven-segment display
// driver's detect_counter input directly.
//
// Both data_in and step_in come from a switch and a button, so each one runs
// through a two-flop synchronizer; the step strobe is then edge detected so a
// held button produces exactly one sample.
//
// Ports:
//   clk      100 MHz system clock
//   reset_n  asynchronous active-low reset, zeroes every register
//   bus      seq_detect_counter_if.slave
//              data_in / step_in   asynchronous user inputs
//              clear_in            synchronous clear (clk domain)
//              detect_counter      saturating match count
//              detect_pulse        one-cycle pulse per match
//              saturated           detect_counter == CNT_MAX
//              history             last PAT_LEN sampled bits
//
// Parameters:
//   PAT_LEN  pattern length in bits (2..8)
//   PATTERN  target sequence, MSB is the oldest bit received
//   CNT_MAX  saturation value of detect_counter
//
// Build option:
//   SEQ_DETECT_NO_OVERLAP_EN  when defined, a match empties the history and
//                             the received-bit count, so the next match needs
//                             PAT_LEN fresh bits (non-overlapping detection).
//                             When undefined, overlapping matches count.
//
// Timing: a step_in rise first captured at edge k shows up as step_edge during
// cycle k+1 -> k+2; history, detect_counter and detect_pulse all update at
// edge k+2.
// -----------------------------------------------------------------------------
module seq_detect_counter #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter logic [7:0]         CNT_MAX = 8'd255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seq_detect_counter_if.slave  bus
);

  // bit_cnt must hold 0..PAT_LEN inclusive
  localparam int                BIT_W    = $clog2(PAT_LEN + 1);
  localparam logic [BIT_W-1:0]  BIT_FULL = BIT_W'(PAT_LEN);
  localparam logic [BIT_W-1:0]  BIT_MIN  = BIT_W'(PAT_LEN - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Synchronizer and edge-detect registers (never touched by clear_in)
  logic data_sync1_q, data_sync1_d;
  logic data_sync2_q, data_sync2_d;
  logic step_sync1_q, step_sync1_d;
  logic step_sync2_q, step_sync2_d;
  logic step_prev_q,  step_prev_d;

  // Detector state
  state_t             state_q,   state_d;
  logic [PAT_LEN-1:0] history_q, history_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]         count_q,   count_d;
  logic               pulse_q,   pulse_d;
  logic               sat_q,     sat_d;

  logic               step_edge;
  logic               capture;
  logic               match;
  logic [PAT_LEN-1:0] shifted;

  // The history as it will look after this step is taken; the match is judged
  // on this new value so the pulse lands on the same edge as the shift.
  assign shifted   = {history_q[PAT_LEN-2:0], data_sync2_q};

  // step_edge can never be high two cycles in a row, so it always arrives
  // while the FSM is back in IDLE; gating on IDLE keeps one capture per rise.
  assign step_edge = step_sync2_q & ~step_prev_q;
  assign capture   = step_edge && (state_q == IDLE);

  // bit_cnt guard stops a zero-filled history from matching a pattern that
  // has leading zeros before PAT_LEN real bits have arrived.
  assign match     = capture && (shifted == PATTERN) && (bit_cnt_q >= BIT_MIN);

  // Next-state logic for every register in the block. The synchronizer chain
  // simply advances each cycle. The detector registers react to clear first,
  // then to a captured step and a possible match.
  always_comb begin
    data_sync1_d = bus.data_in;
    data_sync2_d = data_sync1_q;
    step_sync1_d = bus.step_in;
    step_sync2_d = step_sync1_q;
    step_prev_d  = step_sync2_q;

    state_d      = IDLE;
    history_d    = history_q;
    bit_cnt_d    = bit_cnt_q;
    count_d      = count_q;
    pulse_d      = 1'b0;
    sat_d        = sat_q;

    if (bus.clear_in) begin
      // Clear beats a coincident step; that step's bit is dropped.
      state_d   = IDLE;
      history_d = '0;
      bit_cnt_d = '0;
      count_d   = '0;
      pulse_d   = 1'b0;
      sat_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (capture) begin
            state_d   = SHIFT;
            history_d = shifted;
            if (bit_cnt_q < BIT_FULL) begin
              bit_cnt_d = bit_cnt_q + BIT_ONE;
            end
          end
        end
        SHIFT: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (match) begin
        // The pulse still fires at saturation; only the count holds.
        pulse_d = 1'b1;
        if (count_q < CNT_MAX) begin
          count_d = count_q + 8'd1;
        end
`ifdef SEQ_DETECT_NO_OVERLAP_EN
        history_d = '0;
        bit_cnt_d = '0;
`else
        history_d = shifted;
`endif
      end

      // Registered so it rises on the same edge the count reaches CNT_MAX.
      sat_d = (count_d == CNT_MAX);
    end
  end

  // All state lives here; reset_n clears everything, including the
  // synchronizers and edge register, so the first post-reset step is clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_sync1_q <= 1'b0;
      data_sync2_q <= 1'b0;
      step_sync1_q <= 1'b0;
      step_sync2_q <= 1'b0;
      step_prev_q  <= 1'b0;
      state_q      <= IDLE;
      history_q    <= '0;
      bit_cnt_q    <= '0;
      count_q      <= '0;
      pulse_q      <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      data_sync1_q <= data_sync1_d;
      data_sync2_q <= data_sync2_d;
      step_sync1_q <= step_sync1_d;
      step_sync2_q <= step_sync2_d;
      step_prev_q  <= step_prev_d;
      state_q      <= state_d;
      history_q    <= history_d;
      bit_cnt_q    <= bit_cnt_d;
      count_q      <= count_d;
      pulse_q      <= pulse_d;
      sat_q        <= sat_d;
    end
  end

  assign bus.detect_counter = count_q;
  assign bus.detect_pulse   = pulse_q;
  assign bus.saturated      = sat_q;
  assign bus.history        = history_q;

endmodule

// File: tb/tb_seq_detect_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seq_detect_counter
//
// Two detectors share one set of stimulus: dut_a looks for 1011 and dut_b for
// 0011 (a pattern with leading zeros). A table of bit streams with
// hand-computed results covers the main function; hand-written sequences cover
// latency, saturation, clear/step collision and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_seq_detect_counter;

  logic clk = 1'b0;
  logic reset_n;
  logic data_in;
  logic step_in;
  logic clear_in;

  int assertCnt = 0;
  int failCnt   = 0;
  int pulseCntA = 0;
  int pulseCntB = 0;

  seq_detect_counter_if #(.PAT_LEN(4)) if_a ();
  seq_detect_counter_if #(.PAT_LEN(4)) if_b ();

  assign if_a.data_in  = data_in;
  assign if_a.step_in  = step_in;
  assign if_a.clear_in = clear_in;
  assign if_b.data_in  = data_in;
  assign if_b.step_in  = step_in;
  assign if_b.clear_in = clear_in;

  seq_detect_counter #(
    .PAT_LEN (4),
    .PATTERN (4'b1011),
    .CNT_MAX (8'd255)
  ) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  seq_detect_counter #(
    .PAT_LEN (4),
    .PATTERN (4'b0011),
    .CNT_MAX (8'd255)
  ) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Tally one-cycle match pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (if_a.detect_pulse) pulseCntA++;
    if (if_b.detect_pulse) pulseCntB++;
  end

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    logic [7:0]  expCount;
    logic [3:0]  expHist;
    int          expPulses;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCnt++;
    if (actual !== expected) begin
      failCnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One step: present the bit with a rising strobe, hold, then release
  task automatic applyStimulus(input logic b);
    @(negedge clk);
    data_in = b;
    step_in = 1'b1;
    repeat (4) @(negedge clk);
    step_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Oldest bit is bits[n-1]
  task automatic sendStream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(bits[i]);
    end
  endtask

  task automatic doClear();
    @(negedge clk);
    clear_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
  endtask

  initial begin
    int base;
    int baseB;

`ifdef SEQ_DETECT_NO_OVERLAP_EN
    vecs[0] = '{16'b1011,     4, 8'd1, 4'b0000, 1};
    vecs[1] = '{16'b1011011,  7, 8'd1, 4'b0011, 1};
    vecs[2] = '{16'b0000,     4, 8'd0, 4'b0000, 0};
    vecs[3] = '{16'b10111011, 8, 8'd2, 4'b0000, 2};
    vecs[4] = '{16'b1101,     4, 8'd0, 4'b1101, 0};
    vecs[5] = '{16'b101,      3, 8'd0, 4'b0101, 0};
`else
    vecs[0] = '{16'b1011,     4, 8'd1, 4'b1011, 1};
    vecs[1] = '{16'b1011011,  7, 8'd2, 4'b1011, 2};
    vecs[2] = '{16'b0000,     4, 8'd0, 4'b0000, 0};
    vecs[3] = '{16'b10111011, 8, 8'd2, 4'b1011, 2};
    vecs[4] = '{16'b1101,     4, 8'd0, 4'b1101, 0};
    vecs[5] = '{16'b101,      3, 8'd0, 4'b0101, 0};
`endif

    reset_n  = 1'b0;
    data_in  = 1'b0;
    step_in  = 1'b0;
    clear_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_count",   32'(if_a.detect_counter), 32'd0);
    checkOutput("rst_pulse",   32'(if_a.detect_pulse),   32'd0);
    checkOutput("rst_sat",     32'(if_a.saturated),      32'd0);
    checkOutput("rst_history", 32'(if_a.history),        32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // First match and its exact latency
    $display("[TB] latency of first match");
    base = pulseCntA;
    sendStream(16'b101, 3);
    @(negedge clk);
    data_in = 1'b1;
    step_in = 1'b1;
    @(negedge clk);
    checkOutput("lat_pulse_e1", 32'(if_a.detect_pulse), 32'd0);
    @(negedge clk);
    checkOutput("lat_pulse_e2", 32'(if_a.detect_pulse), 32'd0);
    checkOutput("lat_hist_e2",  32'(if_a.history),      32'h5);
    @(negedge clk);
    checkOutput("lat_pulse_e3", 32'(if_a.detect_pulse),   32'd1);
    checkOutput("lat_count_e3", 32'(if_a.detect_counter), 32'd1);
`ifdef SEQ_DETECT_NO_OVERLAP_EN
    checkOutput("lat_hist_e3",  32'(if_a.history),        32'h0);
`else
    checkOutput("lat_hist_e3",  32'(if_a.history),        32'hB);
`endif
    @(negedge clk);
    checkOutput("lat_pulse_e4", 32'(if_a.detect_pulse), 32'd0);
    step_in = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("lat_pulses", 32'(pulseCntA - base), 32'd1);

    // Table of streams
    $display("[TB] stream table");
    for (int v = 0; v < 6; v++) begin
      doClear();
      base = pulseCntA;
      sendStream(vecs[v].bits, vecs[v].nbits);
      checkOutput($sformatf("vec%0d_count", v), 32'(if_a.detect_counter), 32'(vecs[v].expCount));
      checkOutput($sformatf("vec%0d_hist", v),  32'(if_a.history),        32'(vecs[v].expHist));
      checkOutput($sformatf("vec%0d_sat", v),   32'(if_a.saturated),      32'd0);
      checkOutput($sformatf("vec%0d_pulses", v), 32'(pulseCntA - base),   32'(vecs[v].expPulses));
    end

    // Leading-zero pattern 0011 on dut_b
    $display("[TB] leading-zero pattern");
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    baseB = pulseCntB;
    sendStream(16'b011, 3);
    checkOutput("lz_count_3bits", 32'(if_b.detect_counter), 32'd0);
    checkOutput("lz_hist_3bits",  32'(if_b.history),        32'h3);
    checkOutput("lz_pulses_3bits", 32'(pulseCntB - baseB),  32'd0);
    sendStream(16'b10011, 5);
    checkOutput("lz_count_8bits",  32'(if_b.detect_counter), 32'd1);
    checkOutput("lz_pulses_8bits", 32'(pulseCntB - baseB),   32'd1);

    // Saturation
    $display("[TB] saturation");
    doClear();
    base = pulseCntA;
    for (int rep = 1; rep <= 300; rep++) begin
      sendStream(16'b1011, 4);
      if (rep == 254) begin
        checkOutput("sat_count_254", 32'(if_a.detect_counter), 32'd254);
        checkOutput("sat_flag_254",  32'(if_a.saturated),      32'd0);
      end
      if (rep == 255) begin
        checkOutput("sat_count_255", 32'(if_a.detect_counter), 32'd255);
        checkOutput("sat_flag_255",  32'(if_a.saturated),      32'd1);
      end
    end
    checkOutput("sat_count_300",  32'(if_a.detect_counter), 32'd255);
    checkOutput("sat_flag_300",   32'(if_a.saturated),      32'd1);
    checkOutput("sat_pulses_300", 32'(pulseCntA - base),    32'd300);

    // Clear colliding with the step that completes a match
    $display("[TB] clear versus step");
    doClear();
    for (int rep = 0; rep < 5; rep++) sendStream(16'b1011, 4);
    checkOutput("clr_count_pre", 32'(if_a.detect_counter), 32'd5);
    sendStream(16'b101, 3);
    base = pulseCntA;
    @(negedge clk);
    data_in = 1'b1;
    step_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
    checkOutput("clr_count",  32'(if_a.detect_counter), 32'd0);
    checkOutput("clr_pulse",  32'(if_a.detect_pulse),   32'd0);
    checkOutput("clr_hist",   32'(if_a.history),        32'd0);
    checkOutput("clr_sat",    32'(if_a.saturated),      32'd0);
    repeat (10) @(negedge clk);
    checkOutput("clr_held_hist",   32'(if_a.history),     32'd0);
    checkOutput("clr_held_pulses", 32'(pulseCntA - base), 32'd0);
    step_in = 1'b0;
    repeat (3) @(negedge clk);

    // Reset pulse mid-stream
    $display("[TB] reset mid-stream");
    doClear();
    sendStream(16'b1011, 4);
    checkOutput("mrst_count_pre", 32'(if_a.detect_counter), 32'd1);
    sendStream(16'b101, 3);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #0.5;
    checkOutput("mrst_count", 32'(if_a.detect_counter), 32'd0);
    checkOutput("mrst_hist",  32'(if_a.history),        32'd0);
    checkOutput("mrst_pulse", 32'(if_a.detect_pulse),   32'd0);
    #0.5;
    reset_n = 1'b1;
    base = pulseCntA;
    sendStream(16'b1, 1);
    checkOutput("mrst_count_1bit", 32'(if_a.detect_counter), 32'd0);
    checkOutput("mrst_hist_1bit",  32'(if_a.history),        32'h1);
    checkOutput("mrst_pulses_1bit", 32'(pulseCntA - base),   32'd0);
    sendStream(16'b1011, 4);
    checkOutput("mrst_count_full", 32'(if_a.detect_counter), 32'd1);
    checkOutput("mrst_pulses_full", 32'(pulseCntA - base),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/seq_detect_counter.md
Name: seq_detect_counter

Overview:
- Upstream feeder of the 4-digit seven-segment display driver. Samples a serial data bit on each user step strobe and detects a fixed bit pattern in the received stream.
- Keeps an 8-bit saturating count of detections. The count drives the display's 8-bit `detect_counter` input directly.
- Both inputs arrive asynchronously (switch and button), so the block synchronizes them and edge-detects the step strobe internally.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..8).
- PATTERN, 4'b1011, target sequence, MSB = oldest bit received.
- CNT_MAX, 8'd255, saturation value of `detect_counter`.

Ports:
- clk  in  1  100 MHz system clock
- reset_n  in  1  asynchronous, active-low reset
- data_in  in  1  serial data bit (switch), asynchronous
- step_in  in  1  step strobe (debounced button level), asynchronous; a rising edge samples `data_in`
- clear_in  in  1  synchronous active-high clear, already in the clk domain
- detect_counter  out  8  number of pattern matches since reset/clear, saturating
- detect_pulse  out  1  one-cycle pulse per match
- saturated  out  1  high while `detect_counter` == CNT_MAX
- history  out  PAT_LEN  last PAT_LEN sampled bits (debug/LEDs)

Behaviour:
- Clock and reset are fixed: single clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset (`reset_n` = 0, asynchronous): all outputs and internal registers go to 0, including both synchronizer chains and the edge register.
- Synchronizers:
  - `data_in` and `step_in` each pass through 2 flops, giving d_s and s_s.
  - A third flop s_q holds the previous s_s.
  - step_edge = s_s & ~s_q.
- Latency: a `step_in` rise first captured at edge k produces step_edge during cycle k+1 → k+2. The capture happens at edge k+2, where `history`, `detect_counter` and `detect_pulse` all update. Total: 3 clk edges from first sampling.
- Shift on step_edge:
  - `history` <= {history[PAT_LEN-2:0], d_s}.
  - bit_cnt (internal, 0..PAT_LEN) increments and saturates at PAT_LEN.
- Match rule:
  - match = step_edge && ({history[PAT_LEN-2:0], d_s} == PATTERN) && (bit_cnt >= PAT_LEN-1).
  - A match is evaluated on the new value in the same cycle as the shift.
  - No match is possible until PAT_LEN bits have been received since reset/clear.
  - Zero-filled history never matches, even if PATTERN has leading zeros.
- On match:
  - `detect_pulse` <= 1 for exactly one cycle.
  - `detect_counter` <= `detect_counter` + 1 if below CNT_MAX; otherwise it holds.
- `detect_pulse` still asserts at saturation; only the count holds.
- `saturated` is a registered output, high the same cycle `detect_counter` reaches CNT_MAX.
- Overlap (default build): overlapping matches count; `history` is not cleared after a match.
- Clear:
  - `clear_in` = 1 zeroes `detect_counter`, `history`, bit_cnt, `detect_pulse` and `saturated` at the next edge.
  - Clear has priority over a coincident step_edge; that step's bit is discarded.
  - Synchronizer and edge registers are not cleared, so a held `step_in` does not retrigger after clear.
- `step_in` held high: exactly one sample per rising edge, no auto-repeat.
- Reset mid-operation (`reset_n` asserted anywhere, including during a match cycle): immediate zeroing. The first step after release needs PAT_LEN fresh bits before a match.
- Internal FSM (step_edge, match and clear gating): IDLE (waiting for step_edge) → SHIFT (one cycle; history/count update) → IDLE. The cycle counts above are independent of this encoding.

Optional Feature:
- Macro: SEQ_DETECT_NO_OVERLAP_EN.
- Defined:
  - After a match, bit_cnt resets to 0 and `history` to 0 in the same capture edge that pulses `detect_pulse`.
  - A new match therefore requires PAT_LEN fresh bits (non-overlapping detection).
- Undefined: overlapping detection as described above.
- All ports are identical in both builds.

Test Plan:
- Reset released, then steps with data 1,0,1,1 → `detect_pulse` once, 3 edges after the 4th step rise; `detect_counter` = 1; `history` = 4'b1011.
- Stream 1,0,1,1,0,1,1 → `detect_counter` = 2 (default build); 1 with SEQ_DETECT_NO_OVERLAP_EN.
- Stream 0,1,1 after reset with PATTERN = 4'b0011 → no match; add 1,0,0,1,1 → exactly 1 match.
- 300 repetitions of 1,0,1,1 (non-overlapping pattern instances) → `detect_counter` = 255 and `saturated` = 1 from the 255th match; `detect_pulse` still fires on matches 256–300 while the count holds.
- Counter at 5, `clear_in` asserted in the same cycle as a step_edge carrying the final bit of a match → `detect_counter` = 0, no pulse; `step_in` held high gives no further sample.
- `reset_n` pulsed low for 1 ns mid-stream (after bits 1,0,1), then 1 sent → outputs all 0 immediately, no match after the single bit; a full 1,0,1,1 is then needed → count 1.
